hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/sys_defs.sv | 25 ++
 rtl/hc_scoreboard.sv | 57 +++++
 rtl/hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_hazard_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared definitions for the hazard controller: pipeline control state, the
// hard-wired zero register index and a small popcount helper.
package sys_defs;

    // Control states of the hazard controller
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } hc_state_t;

    // x0 is hard-wired to zero and never becomes a scoreboard producer
    localparam logic [4:0] ZERO_REG = 5'd0;

    // Number of set bits in a 32-bit vector (result fits 0..32)
    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'b0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/hc_scoreboard.sv
// Register scoreboard: one busy bit per architectural register, two read
// ports, one set port (issue) and one clear port (writeback). A set and a
// clear of the same index in one cycle leaves the bit set, since the set
// belongs to the newer producer. Bit 0 is tied low.
module hc_scoreboard
    import sys_defs::*;
(
    input  logic       clk,
    input  logic       i_rst,
    input  logic [4:0] i_rd_idx_a,
    input  logic [4:0] i_rd_idx_b,
    output logic       o_busy_a,
    output logic       o_busy_b,
    input  logic       i_set_en,
    input  logic [4:0] i_set_idx,
    input  logic       i_clr_en,
    input  logic [4:0] i_clr_idx,
    output logic       o_next_all_zero,
    output logic [5:0] o_pending_cnt
);

    logic [31:0] r_busy;
    logic [31:0] w_busy_next;
    logic [5:0]  r_pending_cnt;

    // Per-bit next value: set has priority over clear, x0 never busy
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_bit
            if (gi == 0) begin : g_zero
                assign w_busy_next[gi] = 1'b0;
            end else begin : g_reg
                assign w_busy_next[gi] =
                    (i_set_en && (i_set_idx == 5'(gi))) ? 1'b1 :
                    (i_clr_en && (i_clr_idx == 5'(gi))) ? 1'b0 :
                    r_busy[gi];
            end
        end
    endgenerate

    assign o_busy_a        = r_busy[i_rd_idx_a];
    assign o_busy_b        = r_busy[i_rd_idx_b];
    assign o_next_all_zero = (w_busy_next == 32'd0);
    assign o_pending_cnt   = r_pending_cnt;

    // Busy bits and their count, both reflecting the post-edge scoreboard
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_busy        <= '0;
            r_pending_cnt <= '0;
        end else begin
            r_busy        <= w_busy_next;
            r_pending_cnt <= popcount32(w_busy_next);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RAW interlock via a register scoreboard,
// branch flush, and halt draining (ebreak / illegal instruction).
// Optional feature macro: WB_BYPASS_EN -- when defined, a source that matches
// a same-cycle writeback commit is not a hazard (register file write-through).
module hazard_ctrl
    import sys_defs::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid_inst,
    input  logic [4:0] id_ra_idx,
    input  logic [4:0] id_rb_idx,
    input  logic       id_uses_ra,
    input  logic       id_uses_rb,
    input  logic       id_reg_wr,
    input  logic [4:0] id_dest_reg_idx,
    input  logic       id_halt,
    input  logic       id_illegal,
    input  logic       ex_take_branch,
    input  logic       wb_valid_inst,
    input  logic       wb_reg_wr,
    input  logic [4:0] wb_dest_reg_idx,
    output logic       stall_if,
    output logic       bubble_ex,
    output logic       flush_if_id,
    output logic       halted,
    output logic [5:0] pending_cnt
);

    hc_state_t r_state;
    hc_state_t w_state_next;

    logic w_busy_ra;
    logic w_busy_rb;
    logic w_next_all_zero;
    logic w_wb_commit;
    logic w_ra_bypass;
    logic w_rb_bypass;
    logic w_haz_ra;
    logic w_haz_rb;
    logic w_raw_hazard;
    logic w_issue;
    logic w_set_en;

    assign w_wb_commit = wb_valid_inst & wb_reg_wr;

`ifdef WB_BYPASS_EN
    assign w_ra_bypass = w_wb_commit & (wb_dest_reg_idx == id_ra_idx);
    assign w_rb_bypass = w_wb_commit & (wb_dest_reg_idx == id_rb_idx);
`else
    assign w_ra_bypass = 1'b0;
    assign w_rb_bypass = 1'b0;
`endif

    assign w_haz_ra     = id_uses_ra & w_busy_ra & ~w_ra_bypass & (id_ra_idx != ZERO_REG);
    assign w_haz_rb     = id_uses_rb & w_busy_rb & ~w_rb_bypass & (id_rb_idx != ZERO_REG);
    assign w_raw_hazard = id_valid_inst & (w_haz_ra | w_haz_rb);
    assign w_set_en     = w_issue & id_reg_wr & (id_dest_reg_idx != ZERO_REG);

    hc_scoreboard u_scoreboard (
        .clk             (clk),
        .i_rst           (rst),
        .i_rd_idx_a      (id_ra_idx),
        .i_rd_idx_b      (id_rb_idx),
        .o_busy_a        (w_busy_ra),
        .o_busy_b        (w_busy_rb),
        .i_set_en        (w_set_en),
        .i_set_idx       (id_dest_reg_idx),
        .i_clr_en        (w_wb_commit),
        .i_clr_idx       (wb_dest_reg_idx),
        .o_next_all_zero (w_next_all_zero),
        .o_pending_cnt   (pending_cnt)
    );

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and pipeline controls; a taken branch overrides everything
    // except the halted state
    always_comb begin
        w_state_next = r_state;
        stall_if     = 1'b0;
        bubble_ex    = 1'b0;
        flush_if_id  = 1'b0;
        halted       = 1'b0;
        w_issue      = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (ex_take_branch) begin
                    flush_if_id = 1'b1;
                    bubble_ex   = 1'b1;
                end else begin
                    stall_if  = w_raw_hazard;
                    bubble_ex = w_raw_hazard;
                    w_issue   = id_valid_inst & ~w_raw_hazard & ~id_halt & ~id_illegal;
                    if (id_valid_inst && (id_halt || id_illegal)) begin
                        w_state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (ex_take_branch) begin
                    // The halting instruction was on the wrong path
                    flush_if_id  = 1'b1;
                    bubble_ex    = 1'b1;
                    w_state_next = ST_RUN;
                end else begin
                    stall_if  = 1'b1;
                    bubble_ex = 1'b1;
                    if (w_next_all_zero) begin
                        w_state_next = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                halted    = 1'b1;
                stall_if  = 1'b1;
                bubble_ex = 1'b1;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// traffic, every cycle compared against a behavioural reference model.
module tb_hazard_ctrl;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_HALT  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid_inst;
    logic [4:0] id_ra_idx;
    logic [4:0] id_rb_idx;
    logic       id_uses_ra;
    logic       id_uses_rb;
    logic       id_reg_wr;
    logic [4:0] id_dest_reg_idx;
    logic       id_halt;
    logic       id_illegal;
    logic       ex_take_branch;
    logic       wb_valid_inst;
    logic       wb_reg_wr;
    logic [4:0] wb_dest_reg_idx;
    logic       stall_if;
    logic       bubble_ex;
    logic       flush_if_id;
    logic       halted;
    logic [5:0] pending_cnt;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid_inst   (id_valid_inst),
        .id_ra_idx       (id_ra_idx),
        .id_rb_idx       (id_rb_idx),
        .id_uses_ra      (id_uses_ra),
        .id_uses_rb      (id_uses_rb),
        .id_reg_wr       (id_reg_wr),
        .id_dest_reg_idx (id_dest_reg_idx),
        .id_halt         (id_halt),
        .id_illegal      (id_illegal),
        .ex_take_branch  (ex_take_branch),
        .wb_valid_inst   (wb_valid_inst),
        .wb_reg_wr       (wb_reg_wr),
        .wb_dest_reg_idx (wb_dest_reg_idx),
        .stall_if        (stall_if),
        .bubble_ex       (bubble_ex),
        .flush_if_id     (flush_if_id),
        .halted          (halted),
        .pending_cnt     (pending_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_cyc   = 0;

    // Reference model: which registers await a writeback, and the control mode
    bit m_busy[32];
    int m_state;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit m_src_hazard(input logic [4:0] idx, input logic uses);
        bit commit;
        commit = wb_valid_inst && wb_reg_wr;
        if (!uses || idx == 5'd0 || !m_busy[idx]) return 1'b0;
        if (BYP && commit && wb_dest_reg_idx == idx) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int m_pending();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic idle();
        id_valid_inst   = 1'b0;
        id_ra_idx       = 5'd0;
        id_rb_idx       = 5'd0;
        id_uses_ra      = 1'b0;
        id_uses_rb      = 1'b0;
        id_reg_wr       = 1'b0;
        id_dest_reg_idx = 5'd0;
        id_halt         = 1'b0;
        id_illegal      = 1'b0;
        ex_take_branch  = 1'b0;
        wb_valid_inst   = 1'b0;
        wb_reg_wr       = 1'b0;
        wb_dest_reg_idx = 5'd0;
    endtask

    task automatic wb(input logic [4:0] idx);
        wb_valid_inst   = 1'b1;
        wb_reg_wr       = 1'b1;
        wb_dest_reg_idx = idx;
    endtask

    task automatic op(input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb,
                      input logic use_a, input logic use_b, input logic wr);
        id_valid_inst   = 1'b1;
        id_dest_reg_idx = rd;
        id_ra_idx       = ra;
        id_rb_idx       = rb;
        id_uses_ra      = use_a;
        id_uses_rb      = use_b;
        id_reg_wr       = wr;
    endtask

    // One clock: inputs are already driven just after a falling edge
    task automatic cycle(input bit chk);
        bit raw, brn, issue, e_stall, e_bub, e_fl, e_halted;
        bit nb[32];
        #1;
        raw = id_valid_inst && (m_src_hazard(id_ra_idx, id_uses_ra) ||
                                m_src_hazard(id_rb_idx, id_uses_rb));
        brn = ex_take_branch;
        e_halted = (m_state == M_HALT);
        if (m_state == M_HALT) begin
            e_stall = 1; e_bub = 1; e_fl = 0;
        end else if (brn) begin
            e_stall = 0; e_bub = 1; e_fl = 1;
        end else if (m_state == M_DRAIN) begin
            e_stall = 1; e_bub = 1; e_fl = 0;
        end else begin
            e_stall = raw; e_bub = raw; e_fl = 0;
        end
        issue = (m_state == M_RUN) && id_valid_inst && !raw && !brn && !id_halt && !id_illegal;
        if (chk) begin
            check("stall_if",    32'(stall_if),    32'(e_stall));
            check("bubble_ex",   32'(bubble_ex),   32'(e_bub));
            check("flush_if_id", 32'(flush_if_id), 32'(e_fl));
            check("halted",      32'(halted),      32'(e_halted));
            check("pending_cnt", 32'(pending_cnt), 32'(m_pending()));
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            m_state = M_RUN;
        end else begin
            nb = m_busy;
            if (wb_valid_inst && wb_reg_wr) nb[wb_dest_reg_idx] = 1'b0;
            if (issue && id_reg_wr && id_dest_reg_idx != 5'd0) nb[id_dest_reg_idx] = 1'b1;
            m_busy = nb;
            if (m_state == M_RUN && id_valid_inst && (id_halt || id_illegal) && !brn)
                m_state = M_DRAIN;
            else if (m_state == M_DRAIN && brn)
                m_state = M_RUN;
            else if (m_state == M_DRAIN && m_pending() == 0)
                m_state = M_HALT;
        end
        $display("[TB] cyc %0d rst=%0b v=%0b ra=%0d/%0b rb=%0d/%0b rd=%0d/%0b hlt=%0b ill=%0b br=%0b wb=%0b:%0d | stall=%0b bub=%0b fl=%0b halted=%0b pend=%0d",
                 n_cyc, rst, id_valid_inst, id_ra_idx, id_uses_ra, id_rb_idx, id_uses_rb,
                 id_dest_reg_idx, id_reg_wr, id_halt, id_illegal, ex_take_branch,
                 wb_valid_inst && wb_reg_wr, wb_dest_reg_idx,
                 stall_if, bubble_ex, flush_if_id, halted, pending_cnt);
        n_cyc++;
        @(negedge clk);
    endtask

    initial begin
        int stalls;
        int halt_cycles;
        idle();
        rst = 1'b1;
        m_state = M_RUN;
        @(negedge clk);
        cycle(0);
        rst = 1'b0;
        #1;
        check("rst_pending", 32'(pending_cnt), 32'd0);
        check("rst_halted",  32'(halted),      32'd0);
        check("rst_stall",   32'(stall_if),    32'd0);
        @(negedge clk);

        // add x5, then a consumer of x5 waits for the writeback
        idle(); op(5'd5, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1); cycle(1);
        check("raw_pend_one", 32'(pending_cnt), 32'd1);
        idle(); op(5'd6, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1);
        #1; check("raw_stall", 32'(stall_if), 32'd1); check("raw_bubble", 32'(bubble_ex), 32'd1);
        cycle(1);
        cycle(1);
        wb(5'd5);
        #1; check("raw_wb_cycle_stall", 32'(stall_if), BYP ? 32'd0 : 32'd1);
        cycle(1);
        wb_valid_inst = 1'b0; wb_reg_wr = 1'b0;
        #1; check("raw_released", 32'(stall_if), 32'd0);
        cycle(1);
        idle(); wb(5'd6); cycle(1);
        check("raw_pend_zero", 32'(pending_cnt), 32'd0);

        // issue to x5 while x5 commits: the new producer keeps the bit
        idle(); op(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); wb(5'd5); cycle(1);
        check("same_idx_pend", 32'(pending_cnt), 32'd1);
        idle(); op(5'd8, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1);
        #1; check("same_idx_busy", 32'(stall_if), 32'd1);
        cycle(1);
        idle(); wb(5'd5); cycle(1);

        // taken branch beats a RAW hazard
        idle(); op(5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); cycle(1);
        idle(); op(5'd10, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1); ex_take_branch = 1'b1;
        #1;
        check("br_flush",  32'(flush_if_id), 32'd1);
        check("br_bubble", 32'(bubble_ex),   32'd1);
        check("br_stall",  32'(stall_if),    32'd0);
        cycle(1);
        check("br_no_set", 32'(pending_cnt), 32'd1);
        idle(); wb(5'd9); cycle(1);

        // ebreak with x3,x4 busy drains, then halts until reset
        idle(); op(5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); cycle(1);
        idle(); op(5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); cycle(1);
        idle(); id_valid_inst = 1'b1; id_halt = 1'b1; cycle(1);
        idle(); wb(5'd3); cycle(1);
        check("drain_not_halted", 32'(halted), 32'd0);
        idle(); wb(5'd4); cycle(1);
        check("halted_set", 32'(halted), 32'd1);
        idle(); cycle(1);
        ex_take_branch = 1'b1; cycle(1);
        check("halted_sticky", 32'(halted), 32'd1);
        idle(); rst = 1'b1; cycle(1);
        rst = 1'b0;
        #1; check("halt_rst_cleared", 32'(halted), 32'd0);
        @(negedge clk);

        // illegal instruction then a branch while draining returns to RUN
        idle(); op(5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); cycle(1);
        idle(); id_valid_inst = 1'b1; id_illegal = 1'b1; cycle(1);
        idle(); ex_take_branch = 1'b1;
        #1; check("drain_br_flush", 32'(flush_if_id), 32'd1);
        cycle(1);
        idle();
        #1; check("drain_br_run", 32'(stall_if), 32'd0);
        wb(5'd3); cycle(1);

        // x0 destination never tracked, x0 source never stalls
        for (int k = 0; k < 3; k++) begin
            idle(); op(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1); cycle(1);
        end
        check("x0_pend", 32'(pending_cnt), 32'd0);

        // source x7 while x7 commits
        idle(); op(5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); cycle(1);
        idle(); op(5'd11, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0); wb(5'd7);
        stalls = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (!stall_if) break;
            stalls++;
            cycle(1);
            wb_valid_inst = 1'b0; wb_reg_wr = 1'b0;
        end
        check("wb_bypass_stalls", 32'(stalls), BYP ? 32'd0 : 32'd1);
        cycle(1);

        // random traffic against the model
        halt_cycles = 0;
        for (int n = 0; n < 600; n++) begin
            idle();
            rst = ($urandom_range(0, 59) == 0) || (halt_cycles > 4);
            id_valid_inst   = ($urandom_range(0, 9) < 8);
            id_ra_idx       = 5'($urandom_range(0, 7));
            id_rb_idx       = 5'($urandom_range(0, 7));
            id_uses_ra      = 1'($urandom_range(0, 1));
            id_uses_rb      = 1'($urandom_range(0, 1));
            id_reg_wr       = ($urandom_range(0, 3) != 0);
            id_dest_reg_idx = 5'($urandom_range(0, 7));
            id_halt         = ($urandom_range(0, 39) == 0);
            id_illegal      = ($urandom_range(0, 59) == 0);
            ex_take_branch  = ($urandom_range(0, 9) == 0);
            wb_valid_inst   = ($urandom_range(0, 9) < 6);
            wb_reg_wr       = ($urandom_range(0, 9) < 8);
            wb_dest_reg_idx = 5'($urandom_range(0, 7));
            halt_cycles = (m_state == M_HALT) ? halt_cycles + 1 : 0;
            cycle(1);
        end
        rst = 1'b0;
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
